issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Issue controller between the fetcher and the out-of-order back end. It buffers fetched instructions in a small in-order queue and allocates ROB tags sequentially. It issues one instruction per cycle to either the load/store buffer or the reservation station, and stalls whenever the target unit or the ROB is full. It also drains its queue on a pipeline flush. The decode stage reads operands for `out_issue_instr` in the same cycle the issue pulse is visible.

## Interface
Parameters:
- IQ_DEPTH, 4, instruction-queue depth; power of two, at least 2.
- ROB_SIZE, 16, number of ROB tags; power of two; tag width is `` `ROB_TAG_WIDTH``.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; dominates rdy.
- rdy  in  1  chip enable; when low, all state and registered outputs hold.
- in_fetch_valid  in  1  fetcher presents an instruction.
- in_fetch_instr  in  `` `DATA_WIDTH``  instruction word.
- in_fetch_pc  in  `` `DATA_WIDTH``  its PC.
- out_fetch_ready  out  1  queue can accept this cycle.
- in_rob_full, in_rs_full, in_lsb_full  in  1 each  back-end full flags.
- in_flush  in  1  misprediction flush from ROB.
- out_issue_valid  out  1  single-cycle issue pulse.
- out_issue_instr  out  `` `DATA_WIDTH``  issued instruction.
- out_issue_pc  out  `` `DATA_WIDTH``  issued PC.
- out_issue_robtag  out  `` `ROB_TAG_WIDTH``  allocated ROB tag.
- out_issue_to_lsb  out  1  1 = LSB target, 0 = RS target.

## Operation
- Queue: circular buffer with head pointer, tail pointer and a count of width log2(IQ_DEPTH)+1.
- Push: occurs when in_fetch_valid && out_fetch_ready.
- out_fetch_ready = (count != IQ_DEPTH) && state == RUN. It is combinational from registered state. A pop in the same cycle does not free a slot for the push.
- Target classification from the head entry's opcode [6:0]:
  - 0000011 (load) or 0100011 (store): LSB.
  - Any other opcode: RS.
- Issue condition, all of the following:
  - state == RUN;
  - count != 0;
  - !in_rob_full;
  - !(target LSB ? in_lsb_full : in_rs_full);
  - !in_flush.
- On issue:
  - Pop the head entry.
  - Register instr, pc, to_lsb and the current tag counter onto the outputs; out_issue_valid = 1 for exactly one cycle.
  - Tag counter increments modulo ROB_SIZE; it wraps ROB_SIZE-1 -> 0.
- When the issue condition is false, out_issue_valid = 0 next cycle and the data outputs hold their last values.
- State machine:
  - RUN -> FLUSH on in_flush.
  - FLUSH -> RUN unconditionally after one cycle.
  - In FLUSH: no push, no issue.
- Flush:
  - Clears head, tail and count.
  - Resets the tag counter to 0; the ROB resets its pointers to 0 on flush.
  - Forces out_issue_valid = 0 next cycle.
  - A push or issue requested in the flush cycle is discarded.
- The queue stores no bypass path: an instruction pushed at edge N is issuable no earlier than edge N+1.

## Timing
- Reset values:
  - State = RUN; count, head, tail and tag counter = 0.
  - out_issue_valid = 0; out_issue_instr = 0; out_issue_pc = 0; out_issue_robtag = 0; out_issue_to_lsb = 0.
  - out_fetch_ready = 1 in the first cycle after reset.
- Latency: a push captured at edge N makes out_issue_valid high during cycle N+1 to N+2, given a free target.
- Throughput: one push and one issue per cycle sustained when the queue is neither empty nor full.
- Full flags are sampled combinationally in the issue cycle.
- An upstream full flag must fall within the same cycle in which the unit frees a slot. The controller does not look ahead.
- rdy low mid-stream freezes state and outputs, including a high out_issue_valid. Consumers gate their capture with rdy.
- rst high in any cycle, including FLUSH or mid-issue, returns to reset values at the next edge.

## Structure
- Opcode constants (OPC_LOAD, OPC_STORE) and `` `DATA_WIDTH``/`` `ROB_TAG_WIDTH`` live in constant.v; no literals in the module.
- One sub-module: issue_queue, a parameterised synchronous FIFO with push, pop, flush, count and head data. The controller holds the state machine, tag counter, classification and output registers.

## Test plan
- Reset, then push add (0x00208033, PC 0x0) -> next cycle out_issue_valid=1, robtag=0, to_lsb=0; out_fetch_ready=1 throughout.
- Push 5 back-to-back with in_rs_full=1 -> 4 accepted, out_fetch_ready=0 at count 4, no issue. Release in_rs_full -> 4 issues on consecutive cycles with tags 0..3.
- Head is load 0x00012083 with in_lsb_full=1 and in_rs_full=0 -> no issue; lower in_lsb_full -> issue with to_lsb=1.
- Issue 17 instructions with ROB_SIZE=16 -> tags 0..15 then 0.
- Queue holds 3 entries and in_flush pulses while in_fetch_valid=1 -> no issue for 2 cycles, queue empty, out_fetch_ready=0 for 1 cycle. Next issue carries tag 0.
- rdy=0 for 3 cycles with out_issue_valid=1 -> outputs and count frozen; resume on rdy=1 with no duplicate or lost issue.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the issue controller.
//   DATA_WIDTH       : instruction / PC width
//   OPC_LOAD/STORE   : opcodes that route an instruction to the load/store buffer
//   state_t          : controller state machine encoding
//   iq_entry_t       : one instruction-queue entry (instr + pc)
package issue_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } iq_entry_t;

  // Memory ops go to the LSB, everything else to the reservation station.
  function automatic logic is_mem_op(input logic [DATA_WIDTH-1:0] instr);
    return (instr[6:0] == OPC_LOAD) || (instr[6:0] == OPC_STORE);
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Fetch / back-end / issue bus of the issue controller.
//   master : controller side (drives fetch_ready and the issue outputs)
//   slave  : environment side (fetcher, ROB, RS, LSB, decode)
interface issue_ctrl_if
  import issue_ctrl_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic                  in_fetch_valid;
  logic [DATA_WIDTH-1:0] in_fetch_instr;
  logic [DATA_WIDTH-1:0] in_fetch_pc;
  logic                  out_fetch_ready;
  logic                  in_rob_full;
  logic                  in_rs_full;
  logic                  in_lsb_full;
  logic                  in_flush;
  logic                  out_issue_valid;
  logic [DATA_WIDTH-1:0] out_issue_instr;
  logic [DATA_WIDTH-1:0] out_issue_pc;
  logic [TAG_W-1:0]      out_issue_robtag;
  logic                  out_issue_to_lsb;

  modport master (
    input  in_fetch_valid, in_fetch_instr, in_fetch_pc,
    input  in_rob_full, in_rs_full, in_lsb_full, in_flush,
    output out_fetch_ready,
    output out_issue_valid, out_issue_instr, out_issue_pc,
    output out_issue_robtag, out_issue_to_lsb
  );

  modport slave (
    output in_fetch_valid, in_fetch_instr, in_fetch_pc,
    output in_rob_full, in_rs_full, in_lsb_full, in_flush,
    input  out_fetch_ready,
    input  out_issue_valid, out_issue_instr, out_issue_pc,
    input  out_issue_robtag, out_issue_to_lsb
  );
endinterface

// File: rtl/issue_queue.sv
// In-order instruction queue: circular buffer with head/tail pointers.
//   clk, rst : clock, synchronous active-high reset
//   en       : clock enable; all state holds when low
//   push/din : write din at tail
//   pop      : drop head entry (caller guarantees count != 0)
//   flush    : empty the queue; overrides push and pop
//   head     : entry at head pointer (no bypass from din)
//   count    : number of valid entries
module issue_queue
  import issue_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  iq_entry_t        din,
  output iq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr, tail_ptr;

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (!rst && en && !flush && push) mem[tail_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (en) begin
      if (flush) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (push) tail_ptr <= tail_ptr + PTR_W'(1);
        if (pop)  head_ptr <= head_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: buffers fetched instructions, allocates ROB tags in
// order and issues one instruction per cycle to the LSB or the RS.
//   clk, rst : clock, synchronous active-high reset (dominates rdy)
//   rdy      : chip enable; all state and registered outputs hold when low
//   bus      : fetch handshake, back-end full flags, flush, issue outputs
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int ROB_SIZE = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  issue_ctrl_if.master bus
);

  localparam int TAG_W = $clog2(ROB_SIZE);
  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] count;
  iq_entry_t        head;
  iq_entry_t        din;
  logic             push;
  logic             do_issue;
  logic             head_lsb;

  // Ready depends only on registered state; a same-cycle pop does not help.
  assign bus.out_fetch_ready = (count != CNT_W'(IQ_DEPTH)) && (state_q == ST_RUN);
  assign push     = bus.in_fetch_valid && bus.out_fetch_ready;
  assign head_lsb = is_mem_op(head.instr);
  assign din      = '{instr: bus.in_fetch_instr, pc: bus.in_fetch_pc};

  issue_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .push  (push),
    .pop   (do_issue),
    .flush (bus.in_flush),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst)      state_q <= ST_RUN;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_issue = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.in_flush) state_d = ST_FLUSH;
        else do_issue = (count != '0) && !bus.in_rob_full &&
                        !(head_lsb ? bus.in_lsb_full : bus.in_rs_full);
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Tag counter and issue output registers. Data outputs hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q                <= '0;
      bus.out_issue_valid  <= 1'b0;
      bus.out_issue_instr  <= '0;
      bus.out_issue_pc     <= '0;
      bus.out_issue_robtag <= '0;
      bus.out_issue_to_lsb <= 1'b0;
    end else if (rdy) begin
      if (bus.in_flush) begin
        // ROB pointers restart at 0 on flush, so tags do too.
        tag_q               <= '0;
        bus.out_issue_valid <= 1'b0;
      end else if (do_issue) begin
        tag_q                <= tag_q + TAG_W'(1);
        bus.out_issue_valid  <= 1'b1;
        bus.out_issue_instr  <= head.instr;
        bus.out_issue_pc     <= head.pc;
        bus.out_issue_robtag <= tag_q;
        bus.out_issue_to_lsb <= head_lsb;
      end else begin
        bus.out_issue_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl (IQ_DEPTH=4, ROB_SIZE=16).
module tb_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;

  issue_ctrl_if #(.TAG_W(4)) bus ();

  issue_ctrl #(.IQ_DEPTH(4), .ROB_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    bus.in_fetch_valid = 1'b0;
    bus.in_fetch_instr = '0;
    bus.in_fetch_pc    = '0;
    bus.in_rob_full    = 1'b0;
    bus.in_rs_full     = 1'b0;
    bus.in_lsb_full    = 1'b0;
    bus.in_flush       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_fetch_valid = 1'b1;
    bus.in_fetch_instr = instr;
    bus.in_fetch_pc    = pc;
  endtask

  initial begin
    // ---- reset state
    do_reset();
    chk("rst_valid", 64'(bus.out_issue_valid), 64'd0);
    chk("rst_instr", 64'(bus.out_issue_instr), 64'd0);
    chk("rst_pc",    64'(bus.out_issue_pc),    64'd0);
    chk("rst_tag",   64'(bus.out_issue_robtag), 64'd0);
    chk("rst_lsb",   64'(bus.out_issue_to_lsb), 64'd0);
    chk("rst_ready", 64'(bus.out_fetch_ready), 64'd1);

    // ---- single add: push at edge N, issue visible after N+1
    drive(32'h00208033, 32'h0);
    tick();
    bus.in_fetch_valid = 1'b0;
    chk("add_nobypass", 64'(bus.out_issue_valid), 64'd0);
    chk("add_ready",    64'(bus.out_fetch_ready), 64'd1);
    tick();
    chk("add_valid", 64'(bus.out_issue_valid),  64'd1);
    chk("add_instr", 64'(bus.out_issue_instr),  64'h00208033);
    chk("add_tag",   64'(bus.out_issue_robtag), 64'd0);
    chk("add_lsb",   64'(bus.out_issue_to_lsb), 64'd0);
    chk("add_ready2", 64'(bus.out_fetch_ready), 64'd1);
    // reset while valid is high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 64'(bus.out_issue_valid), 64'd0);
    chk("midrst_instr", 64'(bus.out_issue_instr), 64'd0);

    // ---- fill with RS full: 4 of 5 accepted, then drain tags 0..3
    do_reset();
    bus.in_rs_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill_ready%0d", i), 64'(bus.out_fetch_ready), (i < 4) ? 64'd1 : 64'd0);
      drive(32'h00100013 | (32'(i) << 20), 32'(i * 4));
      tick();
      chk($sformatf("fill_noissue%0d", i), 64'(bus.out_issue_valid), 64'd0);
    end
    bus.in_fetch_valid = 1'b0;
    bus.in_rs_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain_valid%0d", k), 64'(bus.out_issue_valid), 64'd1);
      chk($sformatf("drain_tag%0d", k),   64'(bus.out_issue_robtag), 64'(k));
      chk($sformatf("drain_pc%0d", k),    64'(bus.out_issue_pc), 64'(k * 4));
    end
    tick();
    chk("drain_idle",  64'(bus.out_issue_valid), 64'd0);
    chk("drain_hold",  64'(bus.out_issue_pc),    64'd12);
    chk("drain_ready", 64'(bus.out_fetch_ready), 64'd1);

    // ---- load blocked by LSB full, then store routed to LSB while RS full
    do_reset();
    bus.in_lsb_full = 1'b1;
    drive(32'h00012083, 32'h40);
    tick();
    bus.in_fetch_valid = 1'b0;
    tick();
    chk("ld_blocked0", 64'(bus.out_issue_valid), 64'd0);
    tick();
    chk("ld_blocked1", 64'(bus.out_issue_valid), 64'd0);
    bus.in_lsb_full = 1'b0;
    tick();
    chk("ld_valid", 64'(bus.out_issue_valid),  64'd1);
    chk("ld_lsb",   64'(bus.out_issue_to_lsb), 64'd1);
    chk("ld_pc",    64'(bus.out_issue_pc),     64'h40);
    bus.in_rs_full = 1'b1;
    drive(32'h00112023, 32'h44);
    tick();
    bus.in_fetch_valid = 1'b0;
    tick();
    chk("st_valid", 64'(bus.out_issue_valid),  64'd1);
    chk("st_lsb",   64'(bus.out_issue_to_lsb), 64'd1);
    chk("st_tag",   64'(bus.out_issue_robtag), 64'd1);
    bus.in_rs_full = 1'b0;
    // ROB full blocks any target
    bus.in_rob_full = 1'b1;
    drive(32'h00208033, 32'h48);
    tick();
    bus.in_fetch_valid = 1'b0;
    tick();
    chk("robfull_block", 64'(bus.out_issue_valid), 64'd0);
    bus.in_rob_full = 1'b0;
    tick();
    chk("robfull_rel", 64'(bus.out_issue_robtag), 64'd2);

    // ---- 17 back-to-back issues: tags 0..15 then wrap to 0
    do_reset();
    drive(32'h00000013, 32'h0);
    tick();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) drive(32'h00000013, 32'((i + 1) * 4));
      else        bus.in_fetch_valid = 1'b0;
      tick();
      chk($sformatf("wrap_valid%0d", i), 64'(bus.out_issue_valid), 64'd1);
      chk($sformatf("wrap_tag%0d", i),   64'(bus.out_issue_robtag), 64'(i % 16));
      chk($sformatf("wrap_pc%0d", i),    64'(bus.out_issue_pc), 64'(i * 4));
    end

    // ---- flush with 3 queued entries and fetch_valid held high
    do_reset();
    drive(32'h00208033, 32'h100);
    tick();
    bus.in_fetch_valid = 1'b0;
    tick();
    chk("pre_flush_tag", 64'(bus.out_issue_robtag), 64'd0);
    bus.in_rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h00208033, 32'(32'h200 + i * 4));
      tick();
    end
    drive(32'h00208033, 32'h300);
    bus.in_flush   = 1'b1;
    bus.in_rs_full = 1'b0;
    tick();
    bus.in_flush = 1'b0;
    chk("fl_valid0", 64'(bus.out_issue_valid), 64'd0);
    chk("fl_ready0", 64'(bus.out_fetch_ready), 64'd0);
    drive(32'h00208033, 32'h304);
    tick();
    chk("fl_valid1", 64'(bus.out_issue_valid), 64'd0);
    chk("fl_ready1", 64'(bus.out_fetch_ready), 64'd1);
    drive(32'h00208033, 32'h308);
    tick();
    bus.in_fetch_valid = 1'b0;
    chk("fl_empty", 64'(bus.out_issue_valid), 64'd0);
    tick();
    chk("fl_post_valid", 64'(bus.out_issue_valid),  64'd1);
    chk("fl_post_tag",   64'(bus.out_issue_robtag), 64'd0);
    chk("fl_post_pc",    64'(bus.out_issue_pc),     64'h308);
    tick();
    chk("fl_post_idle", 64'(bus.out_issue_valid), 64'd0);

    // ---- rdy low freezes a high issue pulse, then resumes cleanly
    do_reset();
    drive(32'h00208033, 32'h500);
    tick();
    drive(32'h00208033, 32'h504);
    tick();
    bus.in_fetch_valid = 1'b0;
    chk("rdy_first", 64'(bus.out_issue_pc), 64'h500);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz_valid%0d", i), 64'(bus.out_issue_valid),  64'd1);
      chk($sformatf("frz_pc%0d", i),    64'(bus.out_issue_pc),     64'h500);
      chk($sformatf("frz_tag%0d", i),   64'(bus.out_issue_robtag), 64'd0);
    end
    rdy = 1'b1;
    tick();
    chk("resume_valid", 64'(bus.out_issue_valid),  64'd1);
    chk("resume_pc",    64'(bus.out_issue_pc),     64'h504);
    chk("resume_tag",   64'(bus.out_issue_robtag), 64'd1);
    tick();
    chk("resume_idle", 64'(bus.out_issue_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
